pipe_reg_hs: RTL and testbench



---
 rtl/pipe_reg_hs.sv | 152 +++++++++++++++
 tb/tb_pipe_reg_hs.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_hs.sv
// pipe_reg_hs: one pipeline stage register with a valid/ready handshake,
// a 2-entry skid buffer and a synchronous flush.
//
// in_ready and out_valid depend only on registered occupancy state, so
// back-pressure travels one stage per cycle. There is no combinational path
// from out_ready to in_ready.
//
// Optional build macro PIPE_REG_PERF_EN adds two saturating performance
// counters (stall_cnt, bubble_cnt). When the macro is undefined, those ports
// and their logic are absent.
module pipe_reg_hs #(
    parameter int unsigned            WIDTH     = 64,
    parameter logic [WIDTH-1:0]       RESET_VAL = '0,
    parameter int unsigned            CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data
`ifdef PIPE_REG_PERF_EN
    ,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    bubble_cnt
`else
`endif
);

    // Occupancy of the stage: nothing held, main register only, or main plus skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   main_q;
    logic [WIDTH-1:0]   main_d;
    logic [WIDTH-1:0]   skid_q;
    logic [WIDTH-1:0]   skid_d;

    logic               in_fire;
    logic               out_fire;

    // Handshake outputs come straight from the state register.
    always_comb begin
        in_ready  = (state_q != TWO);
        out_valid = (state_q != EMPTY);
        out_data  = main_q;
        in_fire   = in_valid & in_ready;
        out_fire  = out_valid & out_ready;
    end

    // Next occupancy and data movement. The skid entry always drains into main.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            // Every held entry is killed. Data registers keep stale values,
            // which is harmless because out_valid drops.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end else if (in_fire) begin
                        state_d = TWO;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and data registers. Reset drops both entries with no partial transfer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_REG_PERF_EN
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [CNT_W-1:0]   stall_cnt_d;
    logic [CNT_W-1:0]   bubble_cnt_q;
    logic [CNT_W-1:0]   bubble_cnt_d;

    // Saturating event counters. Flush does not clear them.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (!out_valid && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers. Only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Counter ports show the registered values.
    always_comb begin
        stall_cnt  = stall_cnt_q;
        bubble_cnt = bubble_cnt_q;
    end
`else
    // No performance counter state is built in this configuration.
`endif

endmodule

// File: tb/tb_pipe_reg_hs.sv
// tb_pipe_reg_hs: directed and randomised checks for pipe_reg_hs.
// A queue holds the payloads accepted by the stage. It is used to predict
// out_valid, in_ready and the order of out_data.
// Counter checks are built only when PIPE_REG_PERF_EN is defined.
module tb_pipe_reg_hs;

    localparam int unsigned      WIDTH     = 64;
    localparam logic [WIDTH-1:0] RESET_VAL = 64'h0000_0000_DEAD_BEEF;
`ifdef PIPE_REG_PERF_EN
    localparam int unsigned      CNT_W     = 4;
`else
    localparam int unsigned      CNT_W     = 16;
`endif

    logic               clk;
    logic               rst;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
`ifdef PIPE_REG_PERF_EN
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   bubble_cnt;
`endif

    int                 checks;
    int                 failures;
    logic [WIDTH-1:0]   sb[$];
    logic [WIDTH-1:0]   sb_exp;
    logic               model_valid;
    logic               model_ready;

    pipe_reg_hs #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
`ifdef PIPE_REG_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and report it if it fails.
    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the active edge.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor, sampled mid-cycle. Values seen here are the ones
    // the next posedge will act on.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
        end else begin
            model_valid = (sb.size() != 0);
            model_ready = (sb.size() < 2);
            checkOutput("out_valid_model", {63'd0, out_valid}, {63'd0, model_valid});
            checkOutput("in_ready_model", {63'd0, in_ready}, {63'd0, model_ready});
            if (model_valid && out_ready) begin
                sb_exp = sb.pop_front();
                checkOutput("out_data_sb", out_data, sb_exp);
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && model_ready) begin
                sb.push_back(in_data);
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset for two cycles, then release.
        applyStimulus(1'b1, 64'h99, 1'b1, 1'b1);
        applyStimulus(1'b1, 64'h98, 1'b1, 1'b0);
        rst = 1'b1;
        checkOutput("rst_out_data", out_data, RESET_VAL);
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
`ifdef PIPE_REG_PERF_EN
        checkOutput("rst_stall_cnt", {60'd0, stall_cnt}, 64'd0);
        checkOutput("rst_bubble_cnt", {60'd0, bubble_cnt}, 64'd0);
`endif

        // Streaming, one payload per cycle.
        applyStimulus(1'b1, 64'h11, 1'b1, 1'b0);
        checkOutput("stream_11", out_data, 64'h11);
        checkOutput("stream_ready1", {63'd0, in_ready}, 64'd1);
        applyStimulus(1'b1, 64'h22, 1'b1, 1'b0);
        checkOutput("stream_22", out_data, 64'h22);
        checkOutput("stream_ready2", {63'd0, in_ready}, 64'd1);
        applyStimulus(1'b1, 64'h33, 1'b1, 1'b0);
        checkOutput("stream_33", out_data, 64'h33);
        checkOutput("stream_valid", {63'd0, out_valid}, 64'd1);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        checkOutput("stream_drained", {63'd0, out_valid}, 64'd0);

        // Fill the skid buffer, then release the stall.
        applyStimulus(1'b1, 64'hA1, 1'b0, 1'b0);
        checkOutput("skid_ready_one", {63'd0, in_ready}, 64'd1);
        applyStimulus(1'b1, 64'hA2, 1'b0, 1'b0);
        checkOutput("skid_ready_two", {63'd0, in_ready}, 64'd0);
        checkOutput("skid_head_a1", out_data, 64'hA1);
        applyStimulus(1'b1, 64'hA3, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'hA3, 1'b0, 1'b0);
        checkOutput("skid_hold_a1", out_data, 64'hA1);
        checkOutput("skid_hold_ready", {63'd0, in_ready}, 64'd0);
        applyStimulus(1'b1, 64'hA3, 1'b1, 1'b0);
        checkOutput("skid_drain_a2", out_data, 64'hA2);
        checkOutput("skid_drain_ready", {63'd0, in_ready}, 64'd1);
        applyStimulus(1'b1, 64'hA3, 1'b1, 1'b0);
        checkOutput("skid_drain_a3", out_data, 64'hA3);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        checkOutput("skid_empty", {63'd0, out_valid}, 64'd0);

        // Flush in TWO, with a new payload offered during the flush cycle.
        applyStimulus(1'b1, 64'hB1, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'hB2, 1'b0, 1'b0);
        checkOutput("flush_pre_full", {63'd0, in_ready}, 64'd0);
        applyStimulus(1'b1, 64'hB3, 1'b0, 1'b1);
        checkOutput("flush_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("flush_ready", {63'd0, in_ready}, 64'd1);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        checkOutput("flush_no_b3", {63'd0, out_valid}, 64'd0);

        // Flush in ONE. Delivering B4 still counts; accepting B5 is discarded.
        applyStimulus(1'b1, 64'hB4, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'hB5, 1'b1, 1'b1);
        checkOutput("flush_one_valid", {63'd0, out_valid}, 64'd0);

        // Input and output fire together while in ONE.
        applyStimulus(1'b1, 64'hC1, 1'b0, 1'b0);
        checkOutput("sim_c1", out_data, 64'hC1);
        applyStimulus(1'b1, 64'hC2, 1'b1, 1'b0);
        checkOutput("sim_c2", out_data, 64'hC2);
        checkOutput("sim_valid", {63'd0, out_valid}, 64'd1);
        checkOutput("sim_ready", {63'd0, in_ready}, 64'd1);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);

        // Reset while stalled with two held entries.
        applyStimulus(1'b1, 64'hD1, 1'b0, 1'b0);
        applyStimulus(1'b1, 64'hD2, 1'b0, 1'b0);
        rst = 1'b0;
        applyStimulus(1'b1, 64'hD3, 1'b1, 1'b0);
        rst = 1'b1;
        checkOutput("midrst_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("midrst_data", out_data, RESET_VAL);
        checkOutput("midrst_ready", {63'd0, in_ready}, 64'd1);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        checkOutput("midrst_no_emit", {63'd0, out_valid}, 64'd0);

        // Randomised traffic with occasional flushes.
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 64'h1000 + 64'(i),
                          1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
        end
        checkOutput("random_drained", 64'(sb.size()), 64'd0);

`ifdef PIPE_REG_PERF_EN
        // Saturating stall counter, left unchanged by flush and cleared by reset.
        applyStimulus(1'b1, 64'hE1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        end
        checkOutput("perf_stall_sat", {60'd0, stall_cnt}, 64'd15);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b1);
        checkOutput("perf_flush_keep", {60'd0, stall_cnt}, 64'd15);
        rst = 1'b0;
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        rst = 1'b1;
        checkOutput("perf_rst_stall", {60'd0, stall_cnt}, 64'd0);
        checkOutput("perf_rst_bubble", {60'd0, bubble_cnt}, 64'd0);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        checkOutput("perf_bubble_1", {60'd0, bubble_cnt}, 64'd1);
        applyStimulus(1'b1, 64'hF1, 1'b0, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
        checkOutput("perf_stall_3", {60'd0, stall_cnt}, 64'd3);
        checkOutput("perf_bubble_2", {60'd0, bubble_cnt}, 64'd2);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
